// File: rtl/bus_serializer.sv
// Parallel-to-serial framer: valid/ready word input, one-word hold, LSB-first serial output.
// Optional even-parity trailer bit when BUS_SERIALIZER_PARITY_EN is defined.
module bus_serializer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] vin,
  input  logic             vin_valid,
  output logic             vin_ready,
  output logic             vout,
  output logic             vout_valid,
  output logic             vout_last,
  output logic             busy,
  output logic [1:0]       dbg_state_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef BUS_SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_valid_q, hold_valid_d;
  logic             ready_q, ready_d;
  logic             vout_q, vout_d;
  logic             vout_valid_q, vout_valid_d;
  logic             vout_last_q, vout_last_d;
`ifdef BUS_SERIALIZER_PARITY_EN
  logic             parity_q, parity_d;
`endif

  logic             accept;
  logic             pending;
  logic             load;
  logic [WIDTH-1:0] load_word;

  // Handshake: a word transfers on any posedge where vin_valid && vin_ready;
  // vin_ready is a register equal to !hold_valid, so vin is never sampled while the hold is full.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
`ifdef BUS_SERIALIZER_PARITY_EN
    parity_d     = parity_q;
`endif
    accept    = vin_valid && ready_q;
    pending   = hold_valid_q || accept;
    load      = 1'b0;
    load_word = hold_valid_q ? hold_q : vin;

    case (state_q)
      IDLE: load = pending;
      SHIFT: begin
        if (cnt_q == LAST) begin
`ifdef BUS_SERIALIZER_PARITY_EN
          state_d = PARITY;
`else
          if (pending) load = 1'b1;
          else         state_d = IDLE;
`endif
        end else begin
          shreg_d = shreg_q >> 1;
          cnt_d   = cnt_q + CW'(1);
        end
      end
`ifdef BUS_SERIALIZER_PARITY_EN
      PARITY: begin
        if (pending) load = 1'b1;
        else         state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase

    // A load either drains the hold or bypasses it, so the hold is empty afterwards.
    if (load) begin
      state_d      = SHIFT;
      shreg_d      = load_word;
      cnt_d        = '0;
      hold_valid_d = 1'b0;
`ifdef BUS_SERIALIZER_PARITY_EN
      parity_d     = ^load_word;
`endif
    end else if (accept) begin
      hold_d       = vin;
      hold_valid_d = 1'b1;
    end

    ready_d      = !hold_valid_d;
    vout_valid_d = (state_d != IDLE);
    vout_d       = (state_d == SHIFT) ? shreg_d[0] : 1'b0;
`ifdef BUS_SERIALIZER_PARITY_EN
    if (state_d == PARITY) vout_d = parity_d;
    vout_last_d  = (state_d == PARITY);
`else
    vout_last_d  = (state_d == SHIFT) && (cnt_d == LAST);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      cnt_q        <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      ready_q      <= 1'b0;
      vout_q       <= 1'b0;
      vout_valid_q <= 1'b0;
      vout_last_q  <= 1'b0;
`ifdef BUS_SERIALIZER_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      ready_q      <= ready_d;
      vout_q       <= vout_d;
      vout_valid_q <= vout_valid_d;
      vout_last_q  <= vout_last_d;
`ifdef BUS_SERIALIZER_PARITY_EN
      parity_q     <= parity_d;
`endif
    end
  end

  assign vin_ready   = ready_q;
  assign vout        = vout_q;
  assign vout_valid  = vout_valid_q;
  assign vout_last   = vout_last_q;
  assign busy        = (state_q != IDLE) || hold_valid_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_bus_serializer.sv
// Bench for bus_serializer: bit-level scoreboard fed from accepted words, plus directed checks.
// Build with BUS_SERIALIZER_PARITY_EN defined to exercise the parity trailer.
module tb_bus_serializer;

  localparam int W = 4;
`ifdef BUS_SERIALIZER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int FRAME = W + (PAR ? 1 : 0);

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] vin;
  logic         vin_valid;
  logic         vin_ready;
  logic         vout;
  logic         vout_valid;
  logic         vout_last;
  logic         busy;
  logic [1:0]   dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  int run_len = 0;
  int max_run = 0;

  // Each entry is {last, bit} for one expected serial bit.
  logic [1:0] exp_q[$];
  logic [1:0] exp_e;

  bus_serializer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .vin(vin), .vin_valid(vin_valid), .vin_ready(vin_ready),
    .vout(vout), .vout_valid(vout_valid), .vout_last(vout_last), .busy(busy),
    .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is the word's bits LSB first, then (optionally) the XOR of the word.
  task automatic push_word(input logic [W-1:0] w);
    for (int i = 0; i < W; i++)
      exp_q.push_back({(i == W - 1) && !PAR, w[i]});
    if (PAR) exp_q.push_back({1'b1, ^w});
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (vout_valid) begin
        run_len++;
        if (run_len > max_run) max_run = run_len;
        if (exp_q.size() == 0) begin
          check("unexpected_bit", 1, 0);
        end else begin
          exp_e = exp_q.pop_front();
          check("vout_bit", int'(vout), int'(exp_e[0]));
          check("vout_last", int'(vout_last), int'(exp_e[1]));
        end
      end else begin
        run_len = 0;
        check("idle_vout", int'({vout, vout_last}), 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] w, output int waited);
    waited = 0;
    vin = w;
    vin_valid = 1'b1;
    while (!vin_ready && waited < 100) begin
      tick();
      waited++;
    end
    if (waited >= 100) begin
      check("send_timeout", 1, 0);
    end else begin
      push_word(w);
      tick();
    end
    vin_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || busy) && t < 200) begin
      tick();
      t++;
    end
    check("drain_timeout", int'(t >= 200), 0);
    tick();
    check("drained_busy", int'(busy), 0);
    check("drained_ready", int'(vin_ready), 1);
  endtask

  initial begin
    int wt;
    int gap;
    rst = 1'b1;
    vin = '0;
    vin_valid = 1'b0;
    tick();
    tick();
    check("reset_outputs", int'({vin_ready, vout, vout_valid, vout_last, busy}), 0);
    rst = 1'b0;
    tick();
    check("ready_after_reset", int'(vin_ready), 1);

    // Single word: first bit visible right after the accepting edge.
    send(4'b1011, wt);
    check("latency_valid", int'(vout_valid), 1);
    check("latency_bit0", int'(vout), 1);
    check("single_busy", int'(busy), 1);
    drain();

    // Back-to-back: no gap between frames.
    max_run = 0;
    send(4'hA, wt);
    send(4'h5, wt);
    send(4'hF, wt);
    drain();
    check("b2b_run_length", max_run, 3 * FRAME);

    // Hold full: third word must wait until the hold drains.
    send(4'h3, wt);
    send(4'h6, wt);
    check("hold_full_ready", int'(vin_ready), 0);
    check("hold_full_busy", int'(busy), 1);
    send(4'h9, wt);
    check("hold_wait_cycles", wt, FRAME - 1);
    drain();

`ifdef BUS_SERIALIZER_PARITY_EN
    send(4'b0111, wt);
    drain();
    send(4'b0011, wt);
    drain();
`endif

    // Reset mid-frame with a word sitting in the hold.
    send(4'hC, wt);
    send(4'h7, wt);
    rst = 1'b1;
    tick();
    exp_q.delete();
    check("midreset_outputs", int'({vin_ready, vout, vout_valid, vout_last, busy}), 0);
    rst = 1'b0;
    tick();
    check("midreset_ready", int'(vin_ready), 1);
    check("midreset_busy", int'(busy), 0);
    send(4'h9, wt);
    drain();

    // Idle line.
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_valid", int'(vout_valid), 0);
      check("idle_busy", int'(busy), 0);
    end

    // Random words with random gaps.
    for (int i = 0; i < 40; i++) begin
      gap = $urandom_range(0, 5);
      repeat (gap) tick();
      send(W'($urandom_range(0, (1 << W) - 1)), wt);
    end
    drain();
    check("queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
